program_sequencer: RTL and testbench

Fetch-side program sequencer of the DSP: it owns the program counter and a zero-overhead hardware loop stack. It drives the instruction-memory read address `pc`. It consumes the loop set-up and branch controls that the controller decodes from the instruction currently at `pc`. One instruction is issued per clock unless the sequencer is stalled.

---
 rtl/program_sequencer.sv | 97 +++++++++
 tb/tb_program_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// program_sequencer: program counter with a zero-overhead hardware loop stack.
module program_sequencer #(
    parameter int AW    = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         loop_we,
    input  logic [AW-1:0]                loop_end,
    input  logic [CW-1:0]                loop_count,
    input  logic                         br_taken,
    input  logic [AW-1:0]                br_target,
    output logic [AW-1:0]                pc,
    output logic [$clog2(DEPTH+1)-1:0]   loop_depth,
    output logic                         loop_active,
    output logic                         seq_err
);
    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [AW-1:0] st_start [DEPTH];
    logic [AW-1:0] st_end   [DEPTH];
    logic [CW-1:0] st_cnt   [DEPTH];
    logic [IW-1:0] top;
    logic [IW-1:0] wr;
    logic          at_end;
    logic          full;
    logic          push;
    logic          pop;
    logic          dec;
    logic          set_err;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pc_nxt;

    assign loop_active = loop_depth != '0;
    assign full        = loop_depth == DW'(DEPTH);
    assign top         = loop_active ? IW'(loop_depth - DW'(1)) : '0;
    assign wr          = IW'(loop_depth);
    assign pc_inc      = pc + AW'(1);
    assign at_end      = loop_active && pc == st_end[top];

    // A loop set-up on the outer end address wins over that end check.
    always_comb begin
        pc_nxt  = pc_inc;
        push    = 1'b0;
        pop     = 1'b0;
        dec     = 1'b0;
        set_err = 1'b0;
        if (br_taken) begin
            pc_nxt = br_target;
        end else if (loop_we) begin
            if (loop_count == '0) begin
                pc_nxt = loop_end + AW'(1);
            end else if (full) begin
                set_err = 1'b1;
            end else begin
                push    = 1'b1;
                set_err = loop_active && (loop_end == st_end[top] || at_end);
            end
        end else if (at_end) begin
            if (st_cnt[top] > CW'(1)) begin
                pc_nxt = st_start[top];
                dec    = 1'b1;
            end else begin
                pop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= '0;
            loop_depth <= '0;
            seq_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                st_start[i] <= '0;
                st_end[i]   <= '0;
                st_cnt[i]   <= '0;
            end
        end else if (!stall) begin
            pc      <= pc_nxt;
            seq_err <= seq_err | set_err;
            if (push) begin
                st_start[wr] <= pc_inc;
                st_end[wr]   <= loop_end;
                st_cnt[wr]   <= loop_count;
                loop_depth   <= loop_depth + DW'(1);
            end else if (pop) begin
                loop_depth <= loop_depth - DW'(1);
            end else if (dec) begin
                st_cnt[top] <= st_cnt[top] - CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed scenarios plus random traffic against a queue-based sequencer model.
module tb_program_sequencer;
    localparam int AW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 16;
    localparam int DW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          loop_we;
    logic [AW-1:0] loop_end;
    logic [CW-1:0] loop_count;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic [AW-1:0] pc;
    logic [DW-1:0] loop_depth;
    logic          loop_active;
    logic          seq_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [AW-1:0] s;
        logic [AW-1:0] e;
        int            c;
    } ent_t;

    ent_t          stk[$];
    logic [AW-1:0] m_pc;
    bit            m_err;

    always #5 clk = ~clk;

    program_sequencer #(.AW(AW), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .loop_we(loop_we),
        .loop_end(loop_end),
        .loop_count(loop_count),
        .br_taken(br_taken),
        .br_target(br_target),
        .pc(pc),
        .loop_depth(loop_depth),
        .loop_active(loop_active),
        .seq_err(seq_err)
    );

    function automatic bit at(input int a);
        return m_pc == AW'(a);
    endfunction

    task automatic model_clear();
        m_pc  = '0;
        m_err = 1'b0;
        stk.delete();
    endtask

    task automatic do_reset();
        stall   = 1'b0;
        loop_we = 1'b0;
        br_taken = 1'b0;
        reset   = 1'b1;
        #2;
        model_clear();
        reset = 1'b0;
    endtask

    // Apply one instruction's controls, advance the model, and clock once.
    task automatic cycle(input bit we, input int e, input int c, input bit br, input int tgt, input bit s);
        logic [AW-1:0] ea;
        logic [AW-1:0] ta;
        ent_t          x;
        ea         = AW'(e);
        ta         = AW'(tgt);
        loop_we    = we;
        loop_end   = ea;
        loop_count = CW'(c);
        br_taken   = br;
        br_target  = ta;
        stall      = s;
        if (!s) begin
            if (br) begin
                m_pc = ta;
            end else if (we) begin
                if (c == 0) begin
                    m_pc = ea + AW'(1);
                end else if (stk.size() == DEPTH) begin
                    m_err = 1'b1;
                    m_pc  = m_pc + AW'(1);
                end else begin
                    if (stk.size() > 0 && (ea == stk[$].e || m_pc == stk[$].e)) m_err = 1'b1;
                    x.s = m_pc + AW'(1);
                    x.e = ea;
                    x.c = c;
                    stk.push_back(x);
                    m_pc = m_pc + AW'(1);
                end
            end else if (stk.size() > 0 && m_pc == stk[$].e) begin
                x = stk[$];
                if (x.c > 1) begin
                    x.c = x.c - 1;
                    stk[stk.size() - 1] = x;
                    m_pc = x.s;
                end else begin
                    void'(stk.pop_back());
                    m_pc = m_pc + AW'(1);
                end
            end else begin
                m_pc = m_pc + AW'(1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) cycle(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        n_chk++;
        if (pc !== '0 || loop_depth !== '0 || loop_active !== 1'b0 || seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: pc=%0h depth=%0d active=%b err=%b, want pc=0 depth=0 active=0 err=0",
                     pc, loop_depth, loop_active, seq_err);
        end
        reset = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (pc !== AW'(i) || loop_depth !== '0 || seq_err !== 1'b0) begin
                n_fail++;
                $display("FAIL linear[%0d]: pc=%0h depth=%0d err=%b, want pc=%0h depth=0 err=0",
                         i, pc, loop_depth, seq_err, i);
            end
            cycle(0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_single_loop();
        int ep [11] = '{0, 1, 2, 3, 4, 3, 4, 3, 4, 5, 6};
        int ed [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            n_chk++;
            if (pc !== AW'(ep[i]) || loop_depth !== DW'(ed[i])) begin
                n_fail++;
                $display("FAIL single_loop[%0d]: pc=%0h depth=%0d, want pc=%0h depth=%0d",
                         i, pc, loop_depth, ep[i], ed[i]);
            end
            cycle(at(2), 4, 3, 0, 0, 0);
        end
    endtask

    task automatic test_nested();
        int ep [23] = '{0, 1, 2, 3, 4, 3, 4, 5, 6, 1, 2, 3, 4, 3, 4, 5, 6, 7, 8, 9, 10, 16, 17};
        do_reset();
        for (int i = 0; i < 23; i++) begin
            n_chk++;
            if (pc !== AW'(ep[i]) || loop_depth !== DW'(stk.size()) || seq_err !== 1'b0) begin
                n_fail++;
                $display("FAIL nested[%0d]: pc=%0h depth=%0d err=%b, want pc=%0h depth=%0d err=0",
                         i, pc, loop_depth, seq_err, ep[i], stk.size());
            end
            cycle(at(0) || at(2) || at(10), at(0) ? 6 : at(2) ? 4 : 15, at(10) ? 0 : 2, 0, 0, 0);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int k = 0; k <= DEPTH; k++) begin
            if (k == DEPTH) begin
                n_chk++;
                if (loop_depth !== DW'(DEPTH) || seq_err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill: depth=%0d err=%b, want depth=%0d err=0", loop_depth, seq_err, DEPTH);
                end
            end
            cycle(1, 50 - k, 2, 0, 0, 0);
        end
        n_chk++;
        if (loop_depth !== DW'(DEPTH) || seq_err !== 1'b1 || loop_active !== 1'b1 || pc !== AW'(DEPTH + 1)) begin
            n_fail++;
            $display("FAIL overflow: depth=%0d err=%b active=%b pc=%0h, want depth=%0d err=1 active=1 pc=%0h",
                     loop_depth, seq_err, loop_active, pc, DEPTH, DEPTH + 1);
        end
        do_reset();
        cycle(1, 20, 2, 0, 0, 0);
        cycle(1, 20, 3, 0, 0, 0);
        n_chk++;
        if (seq_err !== 1'b1 || loop_depth !== DW'(2) || pc !== AW'(2)) begin
            n_fail++;
            $display("FAIL shared_end: err=%b depth=%0d pc=%0h, want err=1 depth=2 pc=2", seq_err, loop_depth, pc);
        end
        do_reset();
        cycle(1, 3, 2, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 8, 1, 0, 0, 0);
        n_chk++;
        if (seq_err !== 1'b1 || loop_depth !== DW'(2) || pc !== AW'(4)) begin
            n_fail++;
            $display("FAIL push_at_end: err=%b depth=%0d pc=%0h, want err=1 depth=2 pc=4", seq_err, loop_depth, pc);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 0, 0, 0, 0);
            n_chk++;
            if (pc !== m_pc || loop_depth !== DW'(stk.size()) || seq_err !== m_err) begin
                n_fail++;
                $display("FAIL after_push_at_end[%0d]: pc=%0h depth=%0d err=%b, want pc=%0h depth=%0d err=%b",
                         i, pc, loop_depth, seq_err, m_pc, stk.size(), m_err);
            end
        end
    endtask

    task automatic test_branch_stall();
        int ep [7] = '{5, 6, 3, 4, 5, 6, 7};
        do_reset();
        for (int i = 0; i < 6; i++) cycle(at(2), 6, 2, 0, 0, 0);
        cycle(0, 0, 0, 1, 32, 0);
        n_chk++;
        if (pc !== AW'(32) || loop_depth !== DW'(1)) begin
            n_fail++;
            $display("FAIL branch_on_end: pc=%0h depth=%0d, want pc=20 depth=1", pc, loop_depth);
        end
        cycle(0, 0, 0, 1, 5, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 1, 9, 1);
            n_chk++;
            if (pc !== AW'(5) || loop_depth !== DW'(1)) begin
                n_fail++;
                $display("FAIL stall[%0d]: pc=%0h depth=%0d, want pc=5 depth=1", i, pc, loop_depth);
            end
        end
        for (int i = 0; i < 7; i++) begin
            n_chk++;
            if (pc !== AW'(ep[i]) || loop_depth !== DW'(stk.size())) begin
                n_fail++;
                $display("FAIL resume[%0d]: pc=%0h depth=%0d, want pc=%0h depth=%0d",
                         i, pc, loop_depth, ep[i], stk.size());
            end
            cycle(0, 0, 0, 0, 0, 0);
        end
        cycle(0, 0, 0, 1, 2, 0);
        cycle(1, 9, 5, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        reset = 1'b1;
        #1;
        n_chk++;
        if (pc !== '0 || loop_depth !== '0 || loop_active !== 1'b0 || seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_stall: pc=%0h depth=%0d active=%b err=%b, want 0 0 0 0",
                     pc, loop_depth, loop_active, seq_err);
        end
        reset = 1'b0;
        model_clear();
        cycle(0, 0, 0, 0, 0, 0);
        n_chk++;
        if (pc !== AW'(1) || loop_depth !== '0) begin
            n_fail++;
            $display("FAIL after_reset_in_stall: pc=%0h depth=%0d, want pc=1 depth=0", pc, loop_depth);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) do_reset();
            cycle($urandom_range(0, 7) == 0, int'(m_pc) + int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 19) == 0, int'($urandom_range(0, 40)), $urandom_range(0, 9) == 0);
            n_chk++;
            if (pc !== m_pc || loop_depth !== DW'(stk.size()) || loop_active !== (stk.size() != 0) ||
                seq_err !== m_err) begin
                n_fail++;
                $display("FAIL random[%0d]: pc=%0h depth=%0d active=%b err=%b, want pc=%0h depth=%0d err=%b",
                         i, pc, loop_depth, loop_active, seq_err, m_pc, stk.size(), m_err);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        loop_we    = 1'b0;
        loop_end   = '0;
        loop_count = '0;
        br_taken   = 1'b0;
        br_target  = '0;
        model_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_single_loop();
        test_nested();
        test_overflow();
        test_branch_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
